ref_px_server: RTL and testbench
================================

REF_PX_SERVER -- requirements
Module: ref_px_server

Interface
REQ-001 Parameter FRAME_W, 640, reference frame width in pixels.
REQ-002 Parameter FRAME_H, 480, reference frame height in pixels.
REQ-003 Parameter ADDR_W, 19, pixel-memory byte address width.
REQ-004 Parameter DEPTH, 4, max requests in flight (queued plus outstanding).
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 reset_n  in  1  asynchronous, active-low reset.
REQ-007 base_x  in  10  macroblock search-origin column; sampled per accepted request.
REQ-008 base_y  in  9  macroblock search-origin row; sampled per accepted request.
REQ-009 mreq  in  1  pixel request from block comparator.
REQ-010 mx, my  in  4 each  unsigned offsets added to base_x / base_y.
REQ-011 mwait  out  1  high = no new request accepted this cycle.
REQ-012 mvalid  out  1  one-cycle strobe, mpx holds a returned pixel.
REQ-013 mpx  out  8  returned pixel value.
REQ-014 rd_req, rd_addr  out  1, ADDR_W  memory read request and byte address.
REQ-015 rd_wait  in  1  memory stall; request held while high.
REQ-016 rd_valid, rd_data  in  1, 8  in-order read return.

Function
REQ-017 Request accepted in a cycle where mreq=1 and mwait=0; accepted requests are queued FIFO.
REQ-018 Column cx = min(base_x+mx, FRAME_W-1); row cy = min(base_y+my, FRAME_H-1); 11/10-bit sums, no wrap.
REQ-019 rd_addr = cy*FRAME_W + cx, computed at acceptance, stored in a DEPTH-entry address FIFO; multiply by shift-add only.
REQ-020 Issue FSM states: IDLE (rd_req=0) and ISSUE (rd_req=1, rd_addr = FIFO head).
REQ-021 IDLE -> ISSUE when FIFO non-empty; ISSUE pops head when rd_wait=0, stays ISSUE if FIFO still non-empty, else IDLE.
REQ-022 rd_req and rd_addr stable while rd_wait=1.
REQ-023 Outstanding counter +1 on rd_req&!rd_wait, -1 on rd_valid; both in one cycle = unchanged.
REQ-024 inflight = FIFO count + outstanding; mwait = (inflight == DEPTH), from registered state only.
REQ-025 Accept and issue in the same cycle permitted; full FIFO does not bypass (mwait governs).
REQ-026 On rd_valid with outstanding>0: mpx <= rd_data, mvalid <= 1 next cycle; otherwise mvalid <= 0.
REQ-027 rd_valid with outstanding==0 is ignored (no mvalid, counter not underflowed).
REQ-028 Minimum latency acceptance -> rd_req: 1 cycle; rd_valid -> mvalid: 1 cycle.
REQ-029 Responses returned strictly in acceptance order, one mvalid per accepted request.

Reset
REQ-030 reset_n low: FIFO empty, outstanding=0, FSM IDLE, rd_req=0, rd_addr=0, mvalid=0, mpx=0, mwait=0.
REQ-031 Reset mid-operation discards queued and outstanding requests; late rd_valid handled per REQ-027.

Structure
REQ-032 FRAME_W, FRAME_H, ADDR_W, DEPTH defaults and FSM state encoding belong in shared package mpeg2_pkg.
REQ-033 Address FIFO is sub-module px_addr_fifo (push, pop, full, empty, count); rest is top-level.

Verification
REQ-034 base=(0,0), mreq at mx=3,my=2, rd_wait=0, memory latency 2 -> rd_addr=1283 one cycle later; mvalid with memory byte 3 cycles after issue.
REQ-035 base=(636,478), mx=my=15 -> cx=639, cy=479, rd_addr=307199.
REQ-036 rd_wait held high, mreq every cycle -> exactly 4 accepted, mwait=1 thereafter, rd_addr unchanged while stalled.
REQ-037 Memory latency 5, 8 back-to-back requests -> 8 mvalid pulses in request order, mwait toggles, inflight never >4.
REQ-038 reset_n pulsed with 3 outstanding, then 3 rd_valid -> no mvalid, mwait=0, next request served normally.
REQ-039 rd_valid and new issue in same cycle at outstanding=2 -> outstanding stays 2.

Source files
------------

// File: rtl/mpeg2_pkg.sv
// Shared defaults and types for the MPEG-2 reference-pixel path.
// Holds frame geometry, queue depth, issue FSM encoding and the debug view struct.
package mpeg2_pkg;

  localparam int DEF_FRAME_W = 640;
  localparam int DEF_FRAME_H = 480;
  localparam int DEF_ADDR_W  = 19;
  localparam int DEF_DEPTH   = 4;
  localparam int CNT_W       = $clog2(DEF_DEPTH + 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } issue_state_e;

  // Internal occupancy exported for checkers and bring-up.
  typedef struct packed {
    issue_state_e     state;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] fifo_count;
  } px_dbg_t;

endpackage

// File: rtl/px_addr_fifo.sv
// Small synchronous FIFO of computed pixel byte addresses.
// Push is ignored when full, pop is ignored when empty; push and pop may coincide.
module px_addr_fifo
  import mpeg2_pkg::*;
#(
  parameter int W     = DEF_ADDR_W,
  parameter int DEPTH = DEF_DEPTH,
  localparam int CW   = $clog2(DEPTH + 1),
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_next(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ref_px_server.sv
// Reference-frame pixel server: turns (base + offset) requests into clamped byte
// addresses, issues them to memory in order and returns the bytes in order.
module ref_px_server
  import mpeg2_pkg::*;
#(
  parameter int FRAME_W = DEF_FRAME_W,
  parameter int FRAME_H = DEF_FRAME_H,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DEPTH   = DEF_DEPTH
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [9:0]        base_x,
  input  logic [8:0]        base_y,
  input  logic              mreq,
  input  logic [3:0]        mx,
  input  logic [3:0]        my,
  output logic              mwait,
  output logic              mvalid,
  output logic [7:0]        mpx,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_wait,
  input  logic              rd_valid,
  input  logic [7:0]        rd_data,
  output px_dbg_t           dbg
);

  localparam int CW = $clog2(DEPTH + 1);

  // Handshakes: a request transfers on mreq & !mwait; a memory read transfers on
  // rd_req & !rd_wait with rd_req/rd_addr held until then; rd_valid returns one
  // byte per transferred read, in issue order, and is never back-pressured.

  issue_state_e      state;
  issue_state_e      state_nxt;
  logic [10:0]       sum_x;
  logic [9:0]        sum_y;
  logic [9:0]        cx;
  logic [8:0]        cy;
  logic [ADDR_W-1:0] acc_addr;
  logic              accept;
  logic              fifo_pop;
  logic [ADDR_W-1:0] fifo_head;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_count;
  logic [CW-1:0]     outstanding;
  logic [CW:0]       inflight;
  logic              out_inc;
  logic              out_dec;

  // Row base cy*FRAME_W built from the set bits of FRAME_W (640 -> two shifts).
  function automatic logic [ADDR_W-1:0] row_offset(input logic [8:0] row);
    logic [ADDR_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < 16; i++) begin
      if (((FRAME_W >> i) & 1) != 0) acc = acc + (ADDR_W'(row) << i);
    end
    return acc;
  endfunction

  always_comb begin
    sum_x    = {1'b0, base_x} + {7'b0, mx};
    sum_y    = {1'b0, base_y} + {6'b0, my};
    cx       = (sum_x > 11'(FRAME_W - 1)) ? 10'(FRAME_W - 1) : sum_x[9:0];
    cy       = (sum_y > 10'(FRAME_H - 1)) ? 9'(FRAME_H - 1) : sum_y[8:0];
    acc_addr = row_offset(cy) + ADDR_W'(cx);
  end

  // Occupancy counts queued plus issued-but-unreturned; mwait uses registers only.
  assign inflight = {1'b0, fifo_count} + {1'b0, outstanding};
  assign mwait    = (inflight == (CW + 1)'(DEPTH));
  assign accept   = mreq & ~mwait & ~fifo_full;

  px_addr_fifo #(
    .W     (ADDR_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (accept),
    .push_data (acc_addr),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rd_req    = 1'b0;
    rd_addr   = '0;
    fifo_pop  = 1'b0;
    case (state)
      ST_IDLE: begin
        // Entering on the accept edge gives one-cycle acceptance-to-rd_req.
        if (accept || !fifo_empty) state_nxt = ST_ISSUE;
      end
      ST_ISSUE: begin
        rd_req  = 1'b1;
        rd_addr = fifo_head;
        if (!rd_wait) begin
          fifo_pop = 1'b1;
          if ((fifo_count <= CW'(1)) && !accept) state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign out_inc = rd_req & ~rd_wait;
  assign out_dec = rd_valid & (outstanding != '0);

  // Returns with nothing outstanding (e.g. after a reset) are dropped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      outstanding <= '0;
      mvalid      <= 1'b0;
      mpx         <= '0;
    end else begin
      case ({out_inc, out_dec})
        2'b10:   outstanding <= outstanding + CW'(1);
        2'b01:   outstanding <= outstanding - CW'(1);
        default: outstanding <= outstanding;
      endcase
      mvalid <= out_dec;
      if (out_dec) mpx <= rd_data;
    end
  end

  always_comb begin
    dbg.state       = state;
    dbg.outstanding = CNT_W'(outstanding);
    dbg.fifo_count  = CNT_W'(fifo_count);
  end

endmodule

// File: tb/tb_ref_px_server.sv
// Directed bench for ref_px_server: address vector table plus multi-cycle
// sequences, with a behavioural in-order memory and an expected-pixel queue.
module tb_ref_px_server;
  import mpeg2_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [9:0]  base_x;
  logic [8:0]  base_y;
  logic        mreq;
  logic [3:0]  mx;
  logic [3:0]  my;
  logic        mwait;
  logic        mvalid;
  logic [7:0]  mpx;
  logic        rd_req;
  logic [18:0] rd_addr;
  logic        rd_wait;
  logic        rd_valid;
  logic [7:0]  rd_data;
  px_dbg_t     dbg;

  always #5 clk = ~clk;

  ref_px_server dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .base_x   (base_x),
    .base_y   (base_y),
    .mreq     (mreq),
    .mx       (mx),
    .my       (my),
    .mwait    (mwait),
    .mvalid   (mvalid),
    .mpx      (mpx),
    .rd_req   (rd_req),
    .rd_addr  (rd_addr),
    .rd_wait  (rd_wait),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .dbg      (dbg)
  );

  typedef struct {
    logic [9:0]  bx;
    logic [8:0]  by;
    logic [3:0]  ox;
    logic [3:0]  oy;
    logic [18:0] addr;
  } vec_t;

  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          mem_lat = 2;
  int          inflight_m = 0;
  int          out_m = 0;
  logic        exp_mvalid = 1'b0;
  logic        last_issue = 1'b0;
  logic        last_rv = 1'b0;
  logic [7:0]  exp_q[$];
  logic [18:0] exp_addr_q[$];
  logic [18:0] mem_addr_q[$];
  int          mem_due_q[$];
  vec_t        vecs[11];

  function automatic logic [7:0] pixel_of(input logic [18:0] a);
    return a[7:0] ^ a[15:8] ^ {5'b0, a[18:16]} ^ 8'h3c;
  endfunction

  function automatic logic [18:0] model_addr(input int bx, input int by, input int ox, input int oy);
    int cx;
    int cy;
    cx = bx + ox;
    cy = by + oy;
    if (cx > 639) cx = 639;
    if (cy > 479) cy = 479;
    return 19'(cy * 640 + cx);
  endfunction

  task automatic check1(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic checkn(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: check registered outputs, drive memory, advance to next negedge.
  task automatic tick();
    logic        acc;
    logic        iss;
    logic        rv_eff;
    logic [18:0] a;
    check1("mvalid", mvalid, exp_mvalid);
    if (exp_mvalid && mvalid) begin
      if (exp_q.size() == 0) checkn("exp_q_underflow", 1, 0);
      else checkn("mpx", int'(mpx), int'(exp_q.pop_front()));
    end
    check1("mwait", mwait, inflight_m == DEF_DEPTH);
    check1("rd_req", rd_req, exp_addr_q.size() != 0);
    checkn("outstanding", int'(dbg.outstanding), out_m);
    checkn("fifo_count", int'(dbg.fifo_count), exp_addr_q.size());
    acc = mreq && !mwait;
    iss = rd_req && !rd_wait;
    rd_valid = 1'b0;
    rd_data  = '0;
    if (mem_due_q.size() != 0 && mem_due_q[0] <= cyc) begin
      rd_valid = 1'b1;
      rd_data  = pixel_of(mem_addr_q.pop_front());
      void'(mem_due_q.pop_front());
    end
    rv_eff = rd_valid && (out_m > 0);
    if (iss) begin
      if (exp_addr_q.size() == 0) checkn("issue_unexpected", 1, 0);
      else checkn("rd_addr", int'(rd_addr), int'(exp_addr_q.pop_front()));
      mem_addr_q.push_back(rd_addr);
      mem_due_q.push_back(cyc + mem_lat);
    end
    if (acc) begin
      a = model_addr(int'(base_x), int'(base_y), int'(mx), int'(my));
      exp_addr_q.push_back(a);
      exp_q.push_back(pixel_of(a));
    end
    out_m      = out_m + (iss ? 1 : 0) - (rv_eff ? 1 : 0);
    inflight_m = inflight_m + (acc ? 1 : 0) - (rv_eff ? 1 : 0);
    exp_mvalid = rv_eff;
    last_issue = iss;
    last_rv    = rd_valid;
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((inflight_m > 0 || mem_due_q.size() != 0 || exp_mvalid) && n < budget) begin
      tick();
      n++;
    end
    if (n >= budget) checkn("drain_timeout", n, -1);
  endtask

  task automatic do_reset();
    reset_n  = 1'b0;
    mreq     = 1'b0;
    rd_valid = 1'b0;
    rd_wait  = 1'b0;
    #2;
    check1("rst_rd_req", rd_req, 1'b0);
    checkn("rst_rd_addr", int'(rd_addr), 0);
    check1("rst_mvalid", mvalid, 1'b0);
    checkn("rst_mpx", int'(mpx), 0);
    check1("rst_mwait", mwait, 1'b0);
    checkn("rst_outstanding", int'(dbg.outstanding), 0);
    checkn("rst_fifo_count", int'(dbg.fifo_count), 0);
    check1("rst_state", dbg.state == ST_IDLE, 1'b1);
    exp_q.delete();
    exp_addr_q.delete();
    inflight_m = 0;
    out_m      = 0;
    exp_mvalid = 1'b0;
    @(negedge clk);
    cyc++;
    reset_n = 1'b1;
  endtask

  task automatic set_req(input int bx, input int by, input int ox, input int oy);
    base_x = 10'(bx);
    base_y = 9'(by);
    mx     = 4'(ox);
    my     = 4'(oy);
  endtask

  initial begin
    int   n_acc;
    int   n;
    int   n_rv;
    int   n_mv;
    logic seen;
    logic wait_hi;
    logic toggled;
    logic [CNT_W-1:0] pre_out;

    vecs[0]  = '{10'd0,    9'd0,   4'd3,  4'd2,  19'd1283};
    vecs[1]  = '{10'd636,  9'd478, 4'd15, 4'd15, 19'd307199};
    vecs[2]  = '{10'd0,    9'd0,   4'd0,  4'd0,  19'd0};
    vecs[3]  = '{10'd630,  9'd0,   4'd9,  4'd0,  19'd639};
    vecs[4]  = '{10'd630,  9'd0,   4'd10, 4'd0,  19'd639};
    vecs[5]  = '{10'd1023, 9'd511, 4'd15, 4'd15, 19'd307199};
    vecs[6]  = '{10'd100,  9'd200, 4'd5,  4'd7,  19'd132585};
    vecs[7]  = '{10'd639,  9'd479, 4'd0,  4'd0,  19'd307199};
    vecs[8]  = '{10'd10,   9'd470, 4'd1,  4'd9,  19'd306571};
    vecs[9]  = '{10'd10,   9'd470, 4'd1,  4'd10, 19'd306571};
    vecs[10] = '{10'd320,  9'd240, 4'd15, 4'd0,  19'd153935};

    reset_n = 1'b0;
    mreq = 1'b0;
    rd_wait = 1'b0;
    rd_valid = 1'b0;
    rd_data = '0;
    set_req(0, 0, 0, 0);
    @(negedge clk);
    do_reset();

    // Address table, one request each, one-cycle acceptance-to-rd_req.
    mem_lat = 2;
    for (int i = 0; i < 11; i++) begin
      set_req(int'(vecs[i].bx), int'(vecs[i].by), int'(vecs[i].ox), int'(vecs[i].oy));
      mreq = 1'b1;
      tick();
      mreq = 1'b0;
      check1("tbl_rd_req", rd_req, 1'b1);
      checkn("tbl_rd_addr", int'(rd_addr), int'(vecs[i].addr));
      drain(20);
    end

    // Latency: issue, then rd_valid two cycles later, mvalid one after that.
    set_req(0, 0, 3, 2);
    mreq = 1'b1;
    tick();
    mreq = 1'b0;
    tick();
    check1("lat_mvalid_early", mvalid, 1'b0);
    tick();
    check1("lat_mvalid_early2", mvalid, 1'b0);
    tick();
    check1("lat_mvalid", mvalid, 1'b1);
    checkn("lat_mpx", int'(mpx), int'(pixel_of(19'd1283)));
    drain(20);

    // Stall: exactly four accepted, mwait held, address held.
    rd_wait = 1'b1;
    mreq = 1'b1;
    n_acc = 0;
    for (int i = 0; i < 8; i++) begin
      set_req(5, 5, i, 0);
      if (!mwait) n_acc++;
      if (rd_req) checkn("stall_addr", int'(rd_addr), int'(model_addr(5, 5, 0, 0)));
      tick();
    end
    mreq = 1'b0;
    checkn("stall_accepted", n_acc, 4);
    check1("stall_mwait", mwait, 1'b1);
    rd_wait = 1'b0;
    drain(40);

    // Latency 5, eight back-to-back requests.
    mem_lat = 5;
    n_acc = 0;
    n = 0;
    wait_hi = 1'b0;
    toggled = 1'b0;
    mreq = 1'b1;
    while (n_acc < 8 && n < 100) begin
      set_req(200, 100, n_acc, n_acc);
      if (mwait) wait_hi = 1'b1;
      else if (wait_hi) toggled = 1'b1;
      if (!mwait) n_acc++;
      check1("inflight_le_depth", (int'(dbg.fifo_count) + int'(dbg.outstanding)) <= DEF_DEPTH, 1'b1);
      tick();
      n++;
    end
    mreq = 1'b0;
    checkn("burst_accepted", n_acc, 8);
    check1("burst_mwait_toggled", toggled, 1'b1);
    drain(100);
    checkn("burst_exp_empty", exp_q.size(), 0);

    // Return and new issue in one cycle at outstanding=2.
    mem_lat = 2;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      mreq = (i < 3);
      set_req(40, 30, i, 1);
      pre_out = dbg.outstanding;
      tick();
      if (last_issue && last_rv && pre_out == CNT_W'(2)) begin
        checkn("same_cycle_outstanding", int'(dbg.outstanding), 2);
        seen = 1'b1;
      end
    end
    mreq = 1'b0;
    check1("same_cycle_seen", seen, 1'b1);
    drain(40);

    // Reset with three outstanding; late returns must be dropped.
    mem_lat = 10;
    mreq = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_req(60, 70, i, 0);
      tick();
    end
    mreq = 1'b0;
    n = 0;
    while (out_m < 3 && n < 20) begin
      tick();
      n++;
    end
    checkn("pre_reset_outstanding", int'(dbg.outstanding), 3);
    do_reset();
    n_rv = 0;
    n_mv = 0;
    n = 0;
    while ((mem_due_q.size() != 0 || last_rv) && n < 40) begin
      if (mvalid) n_mv++;
      tick();
      if (last_rv) n_rv++;
      n++;
    end
    checkn("late_rd_valid_count", n_rv, 3);
    checkn("late_mvalid_count", n_mv, 0);
    check1("late_mwait", mwait, 1'b0);
    mem_lat = 2;
    set_req(7, 9, 1, 1);
    mreq = 1'b1;
    tick();
    mreq = 1'b0;
    checkn("post_reset_addr", int'(rd_addr), int'(model_addr(7, 9, 1, 1)));
    drain(20);
    checkn("post_reset_exp_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
